// File: rtl/fsm_state_coverage_monitor.sv
// Windowed coverage monitor for an FSM state stream: per-window report of unvisited legal
// states, illegal encodings, saturating transition count and a stuck-state flag.
module fsm_state_coverage_monitor #(
    parameter int unsigned STATE_W     = 2,
    parameter int unsigned NUM_STATES  = 3,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned STUCK_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [STATE_W-1:0]    state_in,
    input  logic                  state_vld,
    output logic                  rpt_valid,
    input  logic                  rpt_ready,
    output logic [2**STATE_W-1:0] rpt_unvisited,
    output logic                  rpt_illegal,
    output logic                  rpt_stuck,
    output logic [CNT_W-1:0]      rpt_trans_cnt
);

    localparam int unsigned NumEnc = 2**STATE_W;
    localparam int unsigned SampW  = $clog2(WINDOW + 1);
    localparam int unsigned RunW   = $clog2(STUCK_LIMIT + 1);

    localparam logic [SampW-1:0]   WindowLast = SampW'(WINDOW);
    localparam logic [RunW-1:0]    StuckLim   = RunW'(STUCK_LIMIT);
    localparam logic [STATE_W:0]   NumLegal   = (STATE_W + 1)'(NUM_STATES);
    localparam logic [CNT_W-1:0]   TransMax   = '1;

    typedef enum logic [1:0] {StIdle, StCollect, StReport} state_e;

    state_e               state_q, state_d;
    logic [NumEnc-1:0]    visited_q, visited_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_W-1:0]     trans_q, trans_d;
    logic [RunW-1:0]      run_q, run_d;
    logic                 stuck_q, stuck_d;
    logic [STATE_W-1:0]   prev_q, prev_d;
    logic [SampW-1:0]     count_q, count_d;
    logic [NumEnc-1:0]    rpt_unvisited_q, rpt_unvisited_d;
    logic                 rpt_illegal_q, rpt_illegal_d;
    logic                 rpt_stuck_q, rpt_stuck_d;
    logic [CNT_W-1:0]     rpt_trans_q, rpt_trans_d;

    logic [NumEnc-1:0]    legal_mask;
    logic                 first, accept, changed;
    logic [NumEnc-1:0]    visited_upd;
    logic                 illegal_upd, stuck_upd;
    logic [CNT_W-1:0]     trans_upd;
    logic [RunW-1:0]      run_upd;
    logic [SampW-1:0]     count_upd;

    always_comb begin
        legal_mask = '0;
        for (int unsigned s = 0; s < NumEnc; s++) begin
            legal_mask[s] = (s < NUM_STATES);
        end
    end

    // Accumulators are all-zero in StIdle, so the first sample needs no special gating
    // beyond suppressing the transition and restarting the run.
    always_comb begin
        first       = (state_q == StIdle);
        accept      = state_vld && (state_q != StReport);
        changed     = !first && (state_in != prev_q);
        visited_upd = visited_q | (NumEnc'(1) << state_in);
        illegal_upd = illegal_q | ({1'b0, state_in} >= NumLegal);
        trans_upd   = (changed && trans_q != TransMax) ? trans_q + CNT_W'(1) : trans_q;
        if (first || changed) begin
            run_upd = RunW'(1);
        end else if (run_q == StuckLim) begin
            run_upd = run_q;
        end else begin
            run_upd = run_q + RunW'(1);
        end
        stuck_upd = stuck_q | (run_upd == StuckLim);
        count_upd = count_q + SampW'(1);
    end

    always_comb begin
        state_d         = state_q;
        visited_d       = visited_q;
        illegal_d       = illegal_q;
        trans_d         = trans_q;
        run_d           = run_q;
        stuck_d         = stuck_q;
        prev_d          = prev_q;
        count_d         = count_q;
        rpt_unvisited_d = rpt_unvisited_q;
        rpt_illegal_d   = rpt_illegal_q;
        rpt_stuck_d     = rpt_stuck_q;
        rpt_trans_d     = rpt_trans_q;

        if (accept) begin
            visited_d = visited_upd;
            illegal_d = illegal_upd;
            trans_d   = trans_upd;
            run_d     = run_upd;
            stuck_d   = stuck_upd;
            prev_d    = state_in;
            count_d   = count_upd;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (accept && count_upd == WindowLast) begin
                    state_d         = StReport;
                    rpt_unvisited_d = ~visited_upd & legal_mask;
                    rpt_illegal_d   = illegal_upd;
                    rpt_stuck_d     = stuck_upd;
                    rpt_trans_d     = trans_upd;
                    // Window is handed off to the report registers; start clean.
                    visited_d       = '0;
                    illegal_d       = 1'b0;
                    trans_d         = '0;
                    run_d           = '0;
                    stuck_d         = 1'b0;
                    prev_d          = '0;
                    count_d         = '0;
                end
            end
            StReport: begin
                if (rpt_ready) begin
                    state_d         = StIdle;
                    rpt_unvisited_d = '0;
                    rpt_illegal_d   = 1'b0;
                    rpt_stuck_d     = 1'b0;
                    rpt_trans_d     = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            visited_q       <= '0;
            illegal_q       <= 1'b0;
            trans_q         <= '0;
            run_q           <= '0;
            stuck_q         <= 1'b0;
            prev_q          <= '0;
            count_q         <= '0;
            rpt_unvisited_q <= '0;
            rpt_illegal_q   <= 1'b0;
            rpt_stuck_q     <= 1'b0;
            rpt_trans_q     <= '0;
        end else begin
            state_q         <= state_d;
            visited_q       <= visited_d;
            illegal_q       <= illegal_d;
            trans_q         <= trans_d;
            run_q           <= run_d;
            stuck_q         <= stuck_d;
            prev_q          <= prev_d;
            count_q         <= count_d;
            rpt_unvisited_q <= rpt_unvisited_d;
            rpt_illegal_q   <= rpt_illegal_d;
            rpt_stuck_q     <= rpt_stuck_d;
            rpt_trans_q     <= rpt_trans_d;
        end
    end

    assign rpt_valid     = (state_q == StReport);
    assign rpt_unvisited = rpt_unvisited_q;
    assign rpt_illegal   = rpt_illegal_q;
    assign rpt_stuck     = rpt_stuck_q;
    assign rpt_trans_cnt = rpt_trans_q;

endmodule

// File: tb/tb_fsm_state_coverage_monitor.sv
// Directed bench for fsm_state_coverage_monitor; a second instance with CNT_W=4 shares the
// stimulus to exercise transition-count saturation.
module tb_fsm_state_coverage_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_in = 2'd1;
    logic       state_vld = 1'b1;
    logic       rpt_ready = 1'b0;

    logic       rpt_valid;
    logic [3:0] rpt_unvisited;
    logic       rpt_illegal;
    logic       rpt_stuck;
    logic [7:0] rpt_trans_cnt;

    logic       s_valid;
    logic [3:0] s_unvisited;
    logic       s_illegal;
    logic       s_stuck;
    logic [3:0] s_trans_cnt;

    logic [14:0] rpt_vec;
    assign rpt_vec = {rpt_valid, rpt_unvisited, rpt_illegal, rpt_stuck, rpt_trans_cnt};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsm_state_coverage_monitor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state_in      (state_in),
        .state_vld     (state_vld),
        .rpt_valid     (rpt_valid),
        .rpt_ready     (rpt_ready),
        .rpt_unvisited (rpt_unvisited),
        .rpt_illegal   (rpt_illegal),
        .rpt_stuck     (rpt_stuck),
        .rpt_trans_cnt (rpt_trans_cnt)
    );

    fsm_state_coverage_monitor #(.CNT_W(4)) dut_sat (
        .clk           (clk),
        .rst_n         (rst_n),
        .state_in      (state_in),
        .state_vld     (state_vld),
        .rpt_valid     (s_valid),
        .rpt_ready     (rpt_ready),
        .rpt_unvisited (s_unvisited),
        .rpt_illegal   (s_illegal),
        .rpt_stuck     (s_stuck),
        .rpt_trans_cnt (s_trans_cnt)
    );

    task automatic send(input logic [1:0] v);
        @(negedge clk);
        state_in  = v;
        state_vld = 1'b1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        state_vld = 1'b0;
        state_in  = 2'd0;
        rpt_ready = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        rpt_ready = 1'b1;
        state_vld = 1'b0;
        @(negedge clk);
        rpt_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        state_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({rpt_valid, rpt_unvisited, rpt_trans_cnt} !== 13'd0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h expected 0", c,
                         {rpt_valid, rpt_unvisited, rpt_trans_cnt});
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rpt_valid, rpt_unvisited, rpt_trans_cnt} !== 13'd0) begin
            errors++;
            $display("FAIL reset_release: got %h expected 0", {rpt_valid, rpt_unvisited, rpt_trans_cnt});
        end
        do_reset();
    endtask

    task automatic test_alternating();
        for (int i = 0; i < 64; i++) send(2'(i % 2));
        checks++;
        if (rpt_valid !== 1'b0) begin
            errors++;
            $display("FAIL alt_early_valid: got %b expected 0", rpt_valid);
        end
        idle_cycle();
        checks++;
        if (rpt_vec !== {1'b1, 4'b0100, 1'b0, 1'b0, 8'd63}) begin
            errors++;
            $display("FAIL alt_report: got %h expected %h", rpt_vec,
                     {1'b1, 4'b0100, 1'b0, 1'b0, 8'd63});
        end
        checks++;
        if ({s_valid, s_trans_cnt} !== {1'b1, 4'd15}) begin
            errors++;
            $display("FAIL sat_trans_cnt: got %b/%0d expected 1/15", s_valid, s_trans_cnt);
        end
        handshake();
        checks++;
        if (rpt_vec !== 15'd0) begin
            errors++;
            $display("FAIL alt_cleared: got %h expected 0", rpt_vec);
        end
    endtask

    task automatic test_stuck();
        for (int i = 0; i < 64; i++) send(2'd2);
        idle_cycle();
        checks++;
        if (rpt_vec !== {1'b1, 4'b0011, 1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL stuck_const: got %h expected %h", rpt_vec,
                     {1'b1, 4'b0011, 1'b0, 1'b1, 8'd0});
        end
        handshake();
        // Run of 15 stays below the limit.
        for (int i = 0; i < 15; i++) send(2'd2);
        for (int i = 0; i < 49; i++) send(2'(i % 2));
        idle_cycle();
        checks++;
        if (rpt_vec !== {1'b1, 4'b0000, 1'b0, 1'b0, 8'd49}) begin
            errors++;
            $display("FAIL stuck_run15: got %h expected %h", rpt_vec,
                     {1'b1, 4'b0000, 1'b0, 1'b0, 8'd49});
        end
        handshake();
        // Run of exactly 16 trips the flag.
        for (int i = 0; i < 16; i++) send(2'd0);
        for (int i = 0; i < 48; i++) send((i % 2 == 0) ? 2'd1 : 2'd0);
        idle_cycle();
        checks++;
        if (rpt_vec !== {1'b1, 4'b0100, 1'b0, 1'b1, 8'd48}) begin
            errors++;
            $display("FAIL stuck_run16: got %h expected %h", rpt_vec,
                     {1'b1, 4'b0100, 1'b0, 1'b1, 8'd48});
        end
        handshake();
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 63; i++) send(2'(i % 3));
        send(2'd3);
        idle_cycle();
        checks++;
        if (rpt_vec !== {1'b1, 4'b0000, 1'b1, 1'b0, 8'd63}) begin
            errors++;
            $display("FAIL illegal_report: got %h expected %h", rpt_vec,
                     {1'b1, 4'b0000, 1'b1, 1'b0, 8'd63});
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 64; i++) send(2'(i % 2));
        idle_cycle();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (rpt_vec !== {1'b1, 4'b0100, 1'b0, 1'b0, 8'd63}) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got %h expected %h", c, rpt_vec,
                         {1'b1, 4'b0100, 1'b0, 1'b0, 8'd63});
            end
            state_vld = 1'b1;
            state_in  = 2'd3;
        end
        @(negedge clk);
        rpt_ready = 1'b1;
        state_vld = 1'b1;
        state_in  = 2'd3;
        @(negedge clk);
        rpt_ready = 1'b0;
        state_vld = 1'b0;
        checks++;
        if (rpt_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_handshake: got %b expected 0", rpt_valid);
        end
        for (int i = 0; i < 63; i++) send(2'd2);
        idle_cycle();
        checks++;
        if (rpt_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_63_samples: got %b expected 0", rpt_valid);
        end
        send(2'd2);
        idle_cycle();
        checks++;
        if (rpt_vec !== {1'b1, 4'b0011, 1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL hold_next_window: got %h expected %h", rpt_vec,
                     {1'b1, 4'b0011, 1'b0, 1'b1, 8'd0});
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 30; i++) send(2'd3);
        do_reset();
        for (int i = 0; i < 64; i++) send((i % 2 == 0) ? 2'd1 : 2'd2);
        checks++;
        if (rpt_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_early_valid: got %b expected 0", rpt_valid);
        end
        idle_cycle();
        checks++;
        if (rpt_vec !== {1'b1, 4'b0001, 1'b0, 1'b0, 8'd63}) begin
            errors++;
            $display("FAIL mid_report: got %h expected %h", rpt_vec,
                     {1'b1, 4'b0001, 1'b0, 1'b0, 8'd63});
        end
        handshake();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (rpt_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_single_report[%0d]: got %b expected 0", c, rpt_valid);
            end
        end
    endtask

    task automatic test_reset_in_report();
        for (int i = 0; i < 64; i++) send(2'd0);
        idle_cycle();
        checks++;
        if (rpt_vec !== {1'b1, 4'b0110, 1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL rr_report: got %h expected %h", rpt_vec,
                     {1'b1, 4'b0110, 1'b0, 1'b1, 8'd0});
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (rpt_vec !== 15'd0) begin
            errors++;
            $display("FAIL rr_dropped: got %h expected 0", rpt_vec);
        end
        @(negedge clk);
        checks++;
        if (rpt_vec !== 15'd0) begin
            errors++;
            $display("FAIL rr_stays_idle: got %h expected 0", rpt_vec);
        end
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_stuck();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_reset_in_report();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
